// File: rtl/debug_step_controller.sv
// Debug-side controller for the pipeline latches: decodes run/step/reset
// commands, drives enable_debug/reset_debug, snapshots the EX-stage latch
// contents plus an enabled-cycle counter, and streams the snapshot out as
// a byte frame: header, snapshot bytes (MSB first), counter (MSB first).
module debug_step_controller #(
  parameter int unsigned DUMP_BYTES = 16,
  parameter logic [7:0]  CMD_RUN    = 8'h43,
  parameter logic [7:0]  CMD_STEP   = 8'h53,
  parameter logic [7:0]  CMD_RST    = 8'h52,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    eop_in,
  input  logic [DUMP_BYTES*8-1:0] dump_data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    enable_debug,
  output logic                    reset_debug,
  output logic                    busy
);

  localparam int unsigned DATA_W      = DUMP_BYTES * 8;
  localparam int unsigned FRAME_BYTES = DUMP_BYTES + 5;
  localparam int unsigned FRAME_W     = FRAME_BYTES * 8;
  localparam int unsigned IDX_W       = $clog2(FRAME_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    STEP    = 3'd2,
    RSTP    = 3'd3,
    CAPTURE = 3'd4,
    DUMP    = 3'd5
  } state_t;

  state_t            state;
  logic [31:0]       cycle_cnt;
  logic [IDX_W-1:0]  byte_idx;
  logic [DATA_W-1:0] snap_data;
  logic [31:0]       snap_cnt;

  logic [IDX_W-1:0]   next_idx_c;
  logic [FRAME_W-1:0] frame_c;
  logic [7:0]         next_byte_c;

  // Select the frame byte that follows the one currently presented.
  always_comb begin
    next_idx_c  = byte_idx + IDX_W'(1);
    frame_c     = {HDR_BYTE, snap_data, snap_cnt};
    next_byte_c = 8'h00;
    for (int unsigned k = 0; k < FRAME_BYTES; k++) begin
      if (next_idx_c == IDX_W'(k)) begin
        next_byte_c = frame_c[FRAME_W-8-8*k +: 8];
      end
    end
  end

  // Enabled-cycle counter; cleared by reset or a debug reset command.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= 32'h0;
    end else if (state == RSTP) begin
      cycle_cnt <= 32'h0;
    end else if (enable_debug) begin
      cycle_cnt <= cycle_cnt + 32'h1;
    end
  end

  // Command FSM with registered outputs, snapshot capture and TX streaming.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tx_data      <= 8'h00;
      tx_valid     <= 1'b0;
      enable_debug <= 1'b0;
      reset_debug  <= 1'b0;
      busy         <= 1'b0;
      byte_idx     <= '0;
      snap_data    <= '0;
      snap_cnt     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_RUN) begin
              state        <= RUN;
              enable_debug <= 1'b1;
              busy         <= 1'b1;
            end else if (rx_data == CMD_STEP) begin
              state        <= STEP;
              enable_debug <= 1'b1;
              busy         <= 1'b1;
            end else if (rx_data == CMD_RST) begin
              state       <= RSTP;
              reset_debug <= 1'b1;
              busy        <= 1'b1;
            end
          end
        end
        RUN: begin
          if (eop_in) begin
            state        <= CAPTURE;
            enable_debug <= 1'b0;
          end
        end
        STEP: begin
          state        <= CAPTURE;
          enable_debug <= 1'b0;
        end
        RSTP: begin
          state       <= IDLE;
          reset_debug <= 1'b0;
          busy        <= 1'b0;
        end
        CAPTURE: begin
          snap_data <= dump_data;
          snap_cnt  <= cycle_cnt;
          byte_idx  <= '0;
          tx_data   <= HDR_BYTE;
          tx_valid  <= 1'b1;
          state     <= DUMP;
        end
        DUMP: begin
          if (tx_ready) begin
            if (byte_idx == LAST_IDX) begin
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
              byte_idx <= '0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              byte_idx <= next_idx_c;
              tx_data  <= next_byte_c;
            end
          end
        end
        default: begin
          state        <= IDLE;
          tx_valid     <= 1'b0;
          enable_debug <= 1'b0;
          reset_debug  <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
